pixel_frame_loader: RTL and testbench

- Upstream feeder for the input thermometer-binarization stage.
- Accepts a stream of raw grayscale pixels, several per beat, over a valid/ready handshake.
- Quantizes each pixel to PARAM_IN_BIT bits by truncation and packs a full PARAM_IN_CNT-pixel frame into a register bank.
- Presents the packed frame, held stable, to the binarization stage with its own valid/ready handshake.

---
 rtl/pixel_frame_loader.sv | 99 +++++++++
 tb/tb_pixel_frame_loader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_loader.sv
// Collects a frame of raw grayscale pixels, several per beat, truncates each to
// PARAM_IN_BIT bits, and presents the packed frame held stable to the binarizer.

module pixel_frame_loader_lane #(
  parameter int PIX_BIT = 8,
  parameter int IN_BIT  = 2
) (
  input  logic [PIX_BIT-1:0] i_pix,
  output logic [IN_BIT-1:0]  o_q
);
  // Truncation: keep only the top bits, no rounding.
  assign o_q = i_pix[PIX_BIT-1 -: IN_BIT];
endmodule

module pixel_frame_loader #(
  parameter int PARAM_IN_CNT   = 784,
  parameter int PARAM_IN_BIT   = 2,
  parameter int PARAM_PIX_BIT  = 8,
  parameter int PARAM_BEAT_PIX = 4
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [PARAM_BEAT_PIX-1:0][PARAM_PIX_BIT-1:0] in_pixels,
  input  logic                                         in_last,
  output logic                                         frame_valid,
  input  logic                                         frame_ready,
  output logic [PARAM_IN_CNT-1:0][PARAM_IN_BIT-1:0]    frame_out,
  output logic                                         err_len
);
  localparam int PARAM_BEATS = PARAM_IN_CNT / PARAM_BEAT_PIX;
  localparam int CNT_W       = (PARAM_BEATS > 1) ? $clog2(PARAM_BEATS) : 1;
  localparam int IDX_W       = (PARAM_IN_CNT > 1) ? $clog2(PARAM_IN_CNT) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PARAM_BEATS - 1);

  typedef enum logic {S_FILL, S_HOLD} state_t;

  state_t                                      r_state;
  logic [CNT_W-1:0]                            r_beat_cnt;
  logic                                        r_err_len;
  logic [PARAM_IN_CNT-1:0][PARAM_IN_BIT-1:0]   r_frame;
  logic [PARAM_BEAT_PIX-1:0][PARAM_IN_BIT-1:0] w_q;
  logic [IDX_W-1:0]                            w_base;
  logic                                        w_accept;

  for (genvar g = 0; g < PARAM_BEAT_PIX; g++) begin : g_lane
    pixel_frame_loader_lane #(
      .PIX_BIT(PARAM_PIX_BIT),
      .IN_BIT (PARAM_IN_BIT)
    ) u_lane (
      .i_pix(in_pixels[g]),
      .o_q  (w_q[g])
    );
  end

  assign in_ready    = (r_state == S_FILL) && !rst;
  assign w_accept    = in_valid && in_ready;
  assign w_base      = IDX_W'(r_beat_cnt) * IDX_W'(PARAM_BEAT_PIX);
  assign frame_valid = (r_state == S_HOLD);
  assign frame_out   = r_frame;
  assign err_len     = r_err_len;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FILL;
      r_beat_cnt <= '0;
      r_err_len  <= 1'b0;
      r_frame    <= '0;
    end else begin
      r_err_len <= 1'b0;
      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            if (r_beat_cnt == LAST_BEAT) begin
              // Final beat closes the frame even if in_last is missing.
              for (int j = 0; j < PARAM_BEAT_PIX; j++)
                r_frame[w_base + IDX_W'(j)] <= w_q[j];
              r_beat_cnt <= '0;
              r_state    <= S_HOLD;
              r_err_len  <= !in_last;
            end else if (in_last) begin
              r_beat_cnt <= '0;
              r_err_len  <= 1'b1;
            end else begin
              for (int j = 0; j < PARAM_BEAT_PIX; j++)
                r_frame[w_base + IDX_W'(j)] <= w_q[j];
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (frame_ready) r_state <= S_FILL;
        end
        default: r_state <= S_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_frame_loader.sv
// Randomized bench for pixel_frame_loader against a queue-based frame model.

module tb_pixel_frame_loader;
  localparam int CNT   = 784;
  localparam int IB    = 2;
  localparam int PB    = 8;
  localparam int BP    = 4;
  localparam int BEATS = CNT / BP;

  logic                      clk = 1'b0;
  logic                      rst, in_valid, in_ready, in_last;
  logic                      frame_valid, frame_ready, err_len;
  logic [BP-1:0][PB-1:0]     in_pixels;
  logic [CNT-1:0][IB-1:0]    frame_out;

  int checks   = 0;
  int failures = 0;

  // Reference: pixels of the frame in progress, the delivered frame, and
  // whether a frame is on offer / an error pulse is due.
  int m_q[$];
  int m_frame[CNT];
  bit m_hold;
  bit m_err;

  always #5 clk = ~clk;

  pixel_frame_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixels  (in_pixels),
    .in_last    (in_last),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_out  (frame_out),
    .err_len    (err_len)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compares the lowest-indexed differing pixel (pixel 0 if all agree).
  task automatic chk_frame(input string tag);
    int idx;
    idx = 0;
    for (int i = CNT - 1; i >= 0; i--)
      if (32'(frame_out[i]) !== 32'(m_frame[i])) idx = i;
    chk($sformatf("%s[%0d]", tag, idx), 32'(frame_out[idx]), 32'(m_frame[idx]));
  endtask

  function automatic logic [BP-1:0][PB-1:0] gen(input int pat);
    logic [BP-1:0][PB-1:0] px;
    for (int j = 0; j < BP; j++) begin
      case (pat)
        1: px[j] = PB'((j % 4) * 64);
        2: case (j % 4)
             0: px[j] = 8'h3F;
             1: px[j] = 8'h40;
             2: px[j] = 8'hBF;
             default: px[j] = 8'hFF;
           endcase
        default: px[j] = PB'($urandom);
      endcase
    end
    return px;
  endfunction

  task automatic cyc(input logic r, input logic v, input logic l, input logic f,
                     input logic [BP-1:0][PB-1:0] px, output bit acc);
    bit rdy;
    @(negedge clk);
    rst = r; in_valid = v; in_last = l; frame_ready = f; in_pixels = px;
    rdy = !r && !m_hold;
    #1 chk("in_ready", 32'(in_ready), 32'(rdy));
    acc = rdy && v;
    @(posedge clk);
    if (r) begin
      m_hold = 0; m_err = 0; m_q.delete();
      for (int i = 0; i < CNT; i++) m_frame[i] = 0;
    end else begin
      m_err = 0;
      if (m_hold) begin
        if (f) m_hold = 0;
      end else if (v) begin
        for (int j = 0; j < BP; j++) m_q.push_back(int'(px[j]) / (1 << (PB - IB)));
        if (m_q.size() == CNT) begin
          for (int i = 0; i < CNT; i++) m_frame[i] = m_q[i];
          m_q.delete();
          m_hold = 1;
          m_err  = !l;
        end else if (l) begin
          m_q.delete();
          m_err = 1;
        end
      end
    end
    #1;
    chk("frame_valid", 32'(frame_valid), 32'(m_hold));
    chk("err_len", 32'(err_len), 32'(m_err));
    if (m_hold) chk_frame("frame_out");
  endtask

  task automatic send_frame(input int nbeats, input int last_at, input int pat,
                            input int gap_pct, input int fr_pct);
    int b, guard;
    bit acc;
    logic v, f;
    b = 0; guard = 0;
    while (b < nbeats && guard < 5000) begin
      v = ($urandom_range(99) >= gap_pct);
      f = ($urandom_range(99) < fr_pct);
      cyc(1'b0, v, (b == last_at), f, gen(pat), acc);
      if (acc) b++;
      guard++;
    end
    if (b < nbeats) chk("send_timeout", 32'(b), 32'(nbeats));
  endtask

  task automatic drain();
    int g;
    bit acc;
    g = 0;
    while (m_hold && g < 50) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, acc);
      g++;
    end
    if (m_hold) chk("drain_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    bit acc;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; frame_ready = 1'b0; in_pixels = '0;
    m_hold = 0; m_err = 0;
    for (int i = 0; i < CNT; i++) m_frame[i] = 0;

    cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, acc);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, gen(0), acc);
    chk_frame("reset_frame");

    // Nominal ramp pattern, then quantization boundary values.
    send_frame(BEATS, BEATS - 1, 1, 0, 100); drain();
    send_frame(BEATS, BEATS - 1, 2, 0, 100); drain();

    // Backpressure: held frame while upstream keeps offering beats.
    send_frame(BEATS, BEATS - 1, 0, 0, 0);
    repeat (10) cyc(1'b0, 1'b1, 1'b0, 1'b0, gen(0), acc);
    send_frame(BEATS, BEATS - 1, 0, 0, 100); drain();

    // Early last on beat 49, then a clean frame.
    send_frame(50, 49, 0, 0, 100);
    send_frame(BEATS, BEATS - 1, 0, 0, 100); drain();

    // Missing last on the final beat.
    send_frame(BEATS, -1, 0, 0, 100); drain();

    // Reset mid-frame.
    send_frame(100, -1, 0, 0, 100);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, gen(0), acc);
    send_frame(BEATS, BEATS - 1, 0, 0, 100); drain();

    // Reset while holding a frame.
    send_frame(BEATS, BEATS - 1, 0, 0, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, acc);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, gen(0), acc);
    send_frame(BEATS, BEATS - 1, 0, 0, 100); drain();

    // Random gaps and random downstream stalls.
    repeat (4) begin
      send_frame(BEATS, BEATS - 1, 0, 25, 50);
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
